// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and helpers for the write-back port arbiter.
package wb_write_arbiter_pkg;

    localparam int unsigned ADDRESS_LEN = 32;
    localparam int unsigned REG_IDX_W   = 4;
    localparam int unsigned REG_COUNT   = 16;

    // One-hot decode of a register index, used to build pending_mask.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_IDX_W-1:0] r);
        return REG_COUNT'(1) << r;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter.
//   slave  : arbiter side (consumes pipeline/side requests, drives register-file write)
//   master : environment side (pipeline, side writer, register file, hazard unit)
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = ADDRESS_LEN,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  pipe_wb_en;
    logic [REG_IDX_W-1:0]  pipe_dest;
    logic [DATA_W-1:0]     pipe_value;
    logic                  side_valid;
    logic                  side_ready;
    logic [REG_IDX_W-1:0]  side_dest;
    logic [DATA_W-1:0]     side_value;
    logic                  rf_wr_en;
    logic [REG_IDX_W-1:0]  rf_dest;
    logic [DATA_W-1:0]     rf_value;
    logic                  stall_req;
    logic [REG_COUNT-1:0]  pending_mask;
    logic [CNT_W-1:0]      fifo_count;

    modport slave (
        input  pipe_wb_en, pipe_dest, pipe_value,
        input  side_valid, side_dest, side_value,
        output side_ready,
        output rf_wr_en, rf_dest, rf_value,
        output stall_req, pending_mask, fifo_count
    );

    modport master (
        output pipe_wb_en, pipe_dest, pipe_value,
        output side_valid, side_dest, side_value,
        input  side_ready,
        input  rf_wr_en, rf_dest, rf_value,
        input  stall_req, pending_mask, fifo_count
    );

endinterface

// File: rtl/wb_side_fifo.sv
// Synchronous FIFO holding buffered side writes as {dest, value}.
// Ports: clk, rst (async active-low), push/push_dest/push_value, pop,
//        head_dest/head_value, full, empty, count, entry_valid, entry_dests.
module wb_side_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = ADDRESS_LEN,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [REG_IDX_W-1:0]          push_dest,
    input  logic [DATA_W-1:0]             push_value,
    input  logic                          pop,
    output logic [REG_IDX_W-1:0]          head_dest,
    output logic [DATA_W-1:0]             head_value,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH*REG_IDX_W-1:0]    entry_dests
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = REG_IDX_W + DATA_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CNT_W'(DEPTH));

    assign {head_dest, head_value} = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // Storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {push_dest, push_value};
    end

    // Slot i is valid when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset         = PTR_W'(i) - rd_ptr[PTR_W-1:0];
        assign entry_valid[i] = (CNT_W'(offset) < count);
        assign entry_dests[i*REG_IDX_W +: REG_IDX_W] = mem[i][ENTRY_W-1 -: REG_IDX_W];
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// write-back path (priority) and a FIFO-buffered side writer, forcing a
// one-cycle stall when side writes starve.
// Ports: clk, rst (async active-low), bus (wb_write_arbiter_if.slave).
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = ADDRESS_LEN,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic                            push;
    logic                            pop;
    logic [REG_IDX_W-1:0]            head_dest;
    logic [DATA_W-1:0]               head_value;
    logic                            full;
    logic                            empty;
    logic [CNT_W-1:0]                count;
    logic [FIFO_DEPTH-1:0]           entry_valid;
    logic [FIFO_DEPTH*REG_IDX_W-1:0] entry_dests;

    logic [STARVE_W-1:0]             starve_cnt;
    logic                            stall;
    logic                            grant_pipe;
    logic                            grant_side;
    logic [REG_COUNT-1:0]            mask;

    logic                            rf_wr_en;
    logic [REG_IDX_W-1:0]            rf_dest;
    logic [DATA_W-1:0]               rf_value;

    wb_side_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_dest   (bus.side_dest),
        .push_value  (bus.side_value),
        .pop         (pop),
        .head_dest   (head_dest),
        .head_value  (head_value),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_dests (entry_dests)
    );

    // Grant decision; the head is granted only from registered FIFO state,
    // so a write accepted this cycle can never bypass to the port.
    assign stall      = (starve_cnt == STARVE_W'(STARVE_MAX)) && !empty;
    assign grant_pipe = !stall && bus.pipe_wb_en;
    assign grant_side = stall || (!bus.pipe_wb_en && !empty);
    assign pop        = grant_side;
    assign push       = bus.side_valid && !full;

    // OR-decode of destinations of all live entries.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (entry_valid[i]) mask = mask | reg_onehot(entry_dests[i*REG_IDX_W +: REG_IDX_W]);
        end
    end

    // Output register and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wr_en   <= 1'b0;
            rf_dest    <= '0;
            rf_value   <= '0;
            starve_cnt <= '0;
        end else begin
            rf_wr_en <= grant_side || grant_pipe;
            if (grant_side) begin
                rf_dest  <= head_dest;
                rf_value <= head_value;
            end else if (grant_pipe) begin
                rf_dest  <= bus.pipe_dest;
                rf_value <= bus.pipe_value;
            end

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (grant_pipe && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign bus.side_ready   = !full;
    assign bus.stall_req    = stall;
    assign bus.pending_mask = mask;
    assign bus.fifo_count   = count;
    assign bus.rf_wr_en     = rf_wr_en;
    assign bus.rf_dest      = rf_dest;
    assign bus.rf_value     = rf_value;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter (DATA_W=32, FIFO_DEPTH=4, STARVE_MAX=4).
module tb_wb_write_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    wb_write_arbiter_if #(.DATA_W(32), .FIFO_DEPTH(4)) bus ();

    wb_write_arbiter #(
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic en, input logic [3:0] dest, input logic [31:0] val);
        check({tag, ".en"},    64'(bus.rf_wr_en), 64'(en));
        check({tag, ".dest"},  64'(bus.rf_dest),  64'(dest));
        check({tag, ".value"}, 64'(bus.rf_value), 64'(val));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b0;
        bus.pipe_wb_en  = 1'b0;
        bus.pipe_dest   = '0;
        bus.pipe_value  = '0;
        bus.side_valid  = 1'b0;
        bus.side_dest   = '0;
        bus.side_value  = '0;

        // Reset, then idle.
        step();
        step();
        rst = 1'b1;
        step();
        check_rf("reset", 1'b0, 4'd0, 32'h0);
        check("reset.stall",   64'(bus.stall_req),    64'd0);
        check("reset.pending", 64'(bus.pending_mask), 64'd0);
        check("reset.count",   64'(bus.fifo_count),   64'd0);
        check("reset.ready",   64'(bus.side_ready),   64'd1);

        // Pipeline write: one cycle latency.
        bus.pipe_wb_en = 1'b1;
        bus.pipe_dest  = 4'd3;
        bus.pipe_value = 32'hDEADBEEF;
        step();
        check_rf("pipe", 1'b1, 4'd3, 32'hDEADBEEF);
        bus.pipe_wb_en = 1'b0;
        step();
        check("pipe.idle_en", 64'(bus.rf_wr_en), 64'd0);

        // Side write into an idle pipeline: two cycles after acceptance.
        bus.side_valid = 1'b1;
        bus.side_dest  = 4'd7;
        bus.side_value = 32'h11;
        check("side.pend_pre", 64'(bus.pending_mask), 64'd0);
        step();
        bus.side_valid = 1'b0;
        check("side.pend",     64'(bus.pending_mask), 64'h80);
        check("side.count",    64'(bus.fifo_count),   64'd1);
        check("side.no_bypass", 64'(bus.rf_wr_en),    64'd0);
        step();
        check_rf("side", 1'b1, 4'd7, 32'h11);
        check("side.pend_post", 64'(bus.pending_mask), 64'd0);
        check("side.count_post", 64'(bus.fifo_count), 64'd0);

        // Starvation: one entry buffered, pipeline busy every cycle.
        bus.side_valid = 1'b1;
        bus.side_dest  = 4'd9;
        bus.side_value = 32'h55;
        bus.pipe_wb_en = 1'b1;
        bus.pipe_dest  = 4'd1;
        bus.pipe_value = 32'h1000;
        step();
        bus.side_valid = 1'b0;
        check_rf("starve.acc", 1'b1, 4'd1, 32'h1000);
        for (int k = 1; k <= 4; k++) begin
            bus.pipe_value = 32'h1000 + 32'(k);
            check($sformatf("starve.nostall%0d", k), 64'(bus.stall_req), 64'd0);
            step();
            check_rf($sformatf("starve.pipe%0d", k), 1'b1, 4'd1, 32'h1000 + 32'(k));
        end
        bus.pipe_value = 32'h1005;
        check("starve.stall", 64'(bus.stall_req), 64'd1);
        step();
        check_rf("starve.side", 1'b1, 4'd9, 32'h55);
        check("starve.stall_clr", 64'(bus.stall_req), 64'd0);
        step();
        check_rf("starve.held", 1'b1, 4'd1, 32'h1005);
        bus.pipe_wb_en = 1'b0;
        step();
        check("starve.idle", 64'(bus.rf_wr_en), 64'd0);

        // Full FIFO with the pipeline continuously busy.
        bus.pipe_wb_en = 1'b1;
        bus.pipe_dest  = 4'd1;
        bus.pipe_value = 32'h2000;
        bus.side_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.side_dest  = 4'(2 + k);
            bus.side_value = 32'hA2 + 32'(k);
            step();
        end
        bus.side_dest  = 4'd6;
        bus.side_value = 32'hA6;
        check("full.ready",   64'(bus.side_ready),   64'd0);
        check("full.count",   64'(bus.fifo_count),   64'd4);
        check("full.pending", 64'(bus.pending_mask), 64'h3C);
        check("full.nostall", 64'(bus.stall_req),    64'd0);
        step();
        check("full.reject", 64'(bus.fifo_count), 64'd4);
        check_rf("full.pipe", 1'b1, 4'd1, 32'h2000);
        check("full.stall", 64'(bus.stall_req), 64'd1);
        step();
        check_rf("full.pop0", 1'b1, 4'd2, 32'hA2);
        check("full.count3", 64'(bus.fifo_count), 64'd3);
        // Push and pop together at count 3.
        bus.pipe_wb_en = 1'b0;
        step();
        bus.side_valid = 1'b0;
        check_rf("pushpop.pop1", 1'b1, 4'd3, 32'hA3);
        check("pushpop.count", 64'(bus.fifo_count),   64'd3);
        check("pushpop.pend",  64'(bus.pending_mask), 64'h70);

        // Async reset with three entries queued.
        bus.pipe_wb_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_rf("areset", 1'b0, 4'd0, 32'h0);
        check("areset.count", 64'(bus.fifo_count),   64'd0);
        check("areset.pend",  64'(bus.pending_mask), 64'd0);
        check("areset.ready", 64'(bus.side_ready),   64'd1);
        check("areset.stall", 64'(bus.stall_req),    64'd0);
        bus.pipe_wb_en = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("post_reset.en%0d", k), 64'(bus.rf_wr_en), 64'd0);
        end
        check("post_reset.count", 64'(bus.fifo_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
